// File: rtl/sprite_pkg.sv
// Shared types and constants for the per-scanline sprite compositor.
package sprite_pkg;

    localparam int N_SPR    = 32;
    localparam int SPR_SIZE = 32;
    localparam int H_ACTIVE = 640;
    localparam int V_TOTAL  = 525;

    // Sized copies of the constants so comparisons stay width-clean.
    localparam logic [10:0] H_LIMIT    = 11'(H_ACTIVE);
    localparam logic [10:0] SPR_ROWS   = 11'(SPR_SIZE);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [4:0]  IDX_LAST   = 5'(N_SPR - 1);
    // FETCH counter value of the final (write-only) cycle of a sprite row.
    localparam logic [5:0]  FETCH_LAST = 6'(SPR_SIZE);

    // Attribute entry layout: {hflip, n_sprite, y, x}; n_sprite == 0 disables it.
    typedef struct packed {
        logic       hflip;
        logic [5:0] n_sprite;
        logic [9:0] y;
        logic [9:0] x;
    } spr_attr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } render_state_t;

    // Line that will be displayed after the current one, wrapping at frame end.
    function automatic logic [9:0] next_line(input logic [9:0] v);
        return (v == V_LAST) ? 10'd0 : v + 10'd1;
    endfunction

endpackage

// File: rtl/sprite_line_buffer.sv
// One H_ACTIVE x 4-bit line buffer: single write port, registered read port,
// and clear-behind-read (the entry read in cycle c is zeroed in cycle c+1).
module sprite_line_buffer
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [9:0] waddr,
    input  logic [3:0] wdata,
    input  logic [9:0] raddr,
    input  logic       clr_en,
    output logic [3:0] rdata
);

    logic [3:0] mem [H_ACTIVE];
    logic       clr_pend;
    logic [9:0] clr_addr;

    // Storage update; a render write wins over a pending clear to the same buffer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end else if (clr_pend) begin
            mem[clr_addr] <= 4'd0;
        end
    end

    // Registered read data and the one-cycle-delayed clear request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata    <= 4'd0;
            clr_pend <= 1'b0;
            clr_addr <= 10'd0;
        end else begin
            rdata    <= ({1'b0, raddr} < H_LIMIT) ? mem[raddr] : 4'd0;
            clr_pend <= clr_en;
            clr_addr <= raddr;
        end
    end

endmodule

// File: rtl/sprite_line_renderer.sv
// Per-scanline sprite compositor. Scans the 32-entry attribute table once per
// line, fetches visible sprite rows for the next line from the sprite ROMs and
// composites them into the even/odd ping-pong line buffer selected by the
// target line parity; the other buffer is read out and cleared behind the read.
// Build option: define SPR_HFLIP_EN to honour the per-entry horizontal flip bit.
module sprite_line_renderer
    import sprite_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        attr_we,
    input  logic [4:0]  attr_addr,
    input  logic [26:0] attr_data,
    input  logic        line_start,
    input  logic [9:0]  vcount,
    input  logic [9:0]  rd_x,
    input  logic        rd_en,
    output logic [5:0]  n_sprite,
    output logic [9:0]  line,
    output logic [5:0]  pixel,
    input  logic [3:0]  color_code,
    output logic [3:0]  color_code_e,
    output logic [3:0]  color_code_o,
    output logic        select,
    output logic        busy,
    output logic        overrun,
    input  logic        overrun_clr,
    output logic [1:0]  fsm_state
);

    logic [26:0]   attr_mem [N_SPR];
    render_state_t state, state_nxt;
    logic [4:0]    idx;
    logic [9:0]    tgt;
    logic [5:0]    cnt;
    logic [9:0]    cur_x;
    logic          cur_hflip;
    spr_attr_t     scan_attr;
    logic [10:0]   diff;
    logic          hit;
    logic          hf_sel;
    logic [4:0]    col;
    logic [10:0]   waddr;
    logic          wr_en;
    logic          rd_ok;

    // Attribute register file; not reset, software loads it before use.
    always_ff @(posedge clk) begin
        if (attr_we) begin
            attr_mem[attr_addr] <= attr_data;
        end
    end

    assign scan_attr = spr_attr_t'(attr_mem[idx]);

`ifdef SPR_HFLIP_EN
    assign hf_sel = scan_attr.hflip;
`else
    logic unused_hflip;
    assign unused_hflip = scan_attr.hflip;
    assign hf_sel       = 1'b0;
`endif

    // Row within the sprite; only meaningful when tgt >= y.
    assign diff = {1'b0, tgt} - {1'b0, scan_attr.y};
    assign hit  = (scan_attr.n_sprite != 6'd0) && (tgt >= scan_attr.y) && (diff < SPR_ROWS);

    assign busy      = (state == SCAN) || (state == FETCH);
    assign fsm_state = state;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a new line_start always restarts the scan from entry 0.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (line_start) state_nxt = SCAN;
            end
            SCAN: begin
                if (line_start)            state_nxt = SCAN;
                else if (hit)              state_nxt = FETCH;
                else if (idx == IDX_LAST)  state_nxt = DONE;
            end
            FETCH: begin
                if (line_start)                state_nxt = SCAN;
                else if (cnt == FETCH_LAST)    state_nxt = (idx == IDX_LAST) ? DONE : SCAN;
            end
            DONE: begin
                state_nxt = line_start ? SCAN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Scan index, target line, fetch counter and the registered ROM address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= 5'd0;
            tgt       <= 10'd0;
            cnt       <= 6'd0;
            cur_x     <= 10'd0;
            cur_hflip <= 1'b0;
            n_sprite  <= 6'd0;
            line      <= 10'd0;
            pixel     <= 6'd0;
        end else if (line_start) begin
            tgt <= next_line(vcount);
            idx <= 5'd0;
            cnt <= 6'd0;
        end else begin
            case (state)
                SCAN: begin
                    if (hit) begin
                        cnt       <= 6'd0;
                        cur_x     <= scan_attr.x;
                        cur_hflip <= hf_sel;
                        n_sprite  <= scan_attr.n_sprite;
                        line      <= {5'd0, diff[4:0]};
                        pixel     <= {1'b0, (hf_sel ? 5'd31 : 5'd0)};
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                FETCH: begin
                    cnt <= cnt + 6'd1;
                    if (cnt < 6'd31) begin
                        pixel <= {1'b0, (cur_hflip ? (5'd30 - cnt[4:0]) : (cnt[4:0] + 5'd1))};
                    end
                    if (cnt == FETCH_LAST) begin
                        idx <= idx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Overrun is sticky; a new overrun beats a clear in the same cycle.
    // select tracks the display buffer parity one cycle behind vcount.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
            select  <= 1'b0;
        end else begin
            if (line_start && busy)  overrun <= 1'b1;
            else if (overrun_clr)    overrun <= 1'b0;
            select <= vcount[0];
        end
    end

    // ROM data for column cnt-1 arrives during FETCH cycle cnt; the write
    // address is always x + (cnt-1) even when the ROM column is mirrored.
    assign col   = cnt[4:0] - 5'd1;
    assign waddr = {1'b0, cur_x} + {6'd0, col};
    assign wr_en = (state == FETCH) && (cnt != 6'd0) && (color_code != 4'd0) && (waddr < H_LIMIT);
    assign rd_ok = rd_en && ({1'b0, rd_x} < H_LIMIT);

    sprite_line_buffer u_buf_even (
        .clk    (clk),
        .reset  (reset),
        .we     (wr_en && !tgt[0]),
        .waddr  (waddr[9:0]),
        .wdata  (color_code),
        .raddr  (rd_x),
        .clr_en (rd_ok && !vcount[0]),
        .rdata  (color_code_e)
    );

    sprite_line_buffer u_buf_odd (
        .clk    (clk),
        .reset  (reset),
        .we     (wr_en && tgt[0]),
        .waddr  (waddr[9:0]),
        .wdata  (color_code),
        .raddr  (rd_x),
        .clr_en (rd_ok && vcount[0]),
        .rdata  (color_code_o)
    );

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer: registered ROM model, line-buffer
// readback through the display port, and a reference compositor per line.
module tb_sprite_line_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic        attr_we;
    logic [4:0]  attr_addr;
    logic [26:0] attr_data;
    logic        line_start;
    logic [9:0]  vcount;
    logic [9:0]  rd_x;
    logic        rd_en;
    logic [5:0]  n_sprite;
    logic [9:0]  line;
    logic [5:0]  pixel;
    logic [3:0]  color_code = 4'd0;
    logic [3:0]  color_code_e;
    logic [3:0]  color_code_o;
    logic        select;
    logic        busy;
    logic        overrun;
    logic        overrun_clr;
    logic [1:0]  fsm_state;

`ifdef SPR_HFLIP_EN
    localparam bit HF_EN = 1'b1;
`else
    localparam bit HF_EN = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    int sh_hf [32];
    int sh_n  [32];
    int sh_y  [32];
    int sh_x  [32];
    int exp_line [640];
    int got_line [640];
    logic [5:0] exp_q [$];
    logic [5:0] pix_q [$];
    int line_max;
    int busy_cnt;
    int span_cnt;
    int first_n;

    sprite_line_renderer dut (
        .clk          (clk),
        .reset        (reset),
        .attr_we      (attr_we),
        .attr_addr    (attr_addr),
        .attr_data    (attr_data),
        .line_start   (line_start),
        .vcount       (vcount),
        .rd_x         (rd_x),
        .rd_en        (rd_en),
        .n_sprite     (n_sprite),
        .line         (line),
        .pixel        (pixel),
        .color_code   (color_code),
        .color_code_e (color_code_e),
        .color_code_o (color_code_o),
        .select       (select),
        .busy         (busy),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .fsm_state    (fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    // Sprite ROM content: columns with col%4==3 are transparent.
    function automatic logic [3:0] rom_code(input int n, input int row, input int c);
        logic [3:0] v;
        v = 4'(n + 2 * row + c);
        if ((c % 4) == 3) v = 4'd0;
        return v;
    endfunction

    // Sprite ROM: data valid one cycle after the address.
    always @(posedge clk) color_code <= rom_code(int'(n_sprite), int'(line), int'(pixel));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_attr(input int i, input int hf, input int n, input int y, input int x);
        tick();
        attr_we   = 1'b1;
        attr_addr = 5'(i);
        attr_data = {1'(hf), 6'(n), 10'(y), 10'(x)};
        tick();
        attr_we   = 1'b0;
        sh_hf[i] = hf; sh_n[i] = n; sh_y[i] = y; sh_x[i] = x;
    endtask

    task automatic clear_attrs();
        for (int i = 0; i < 32; i++) wr_attr(i, 0, 0, 0, 0);
    endtask

    task automatic start_line();
        tick();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    // Runs until IDLE, counting busy cycles and logging the ROM column sequence.
    task automatic run_to_idle();
        busy_cnt = 0; span_cnt = 0; line_max = 0; first_n = -1;
        pix_q.delete();
        while (fsm_state != 2'd0 && span_cnt < 2000) begin
            span_cnt++;
            if (busy) busy_cnt++;
            if (fsm_state == 2'd2) begin
                pix_q.push_back(pixel);
                if (int'(line) > line_max) line_max = int'(line);
                if (first_n < 0) first_n = int'(n_sprite);
            end
            tick();
        end
        if (span_cnt >= 2000) check_eq("render_timeout", span_cnt, 0);
    endtask

    task automatic render(input int vc);
        vcount = 10'(vc);
        start_line();
        run_to_idle();
    endtask

    // Sweeps the display port over a whole line with vcount = vc.
    task automatic read_line(input int vc);
        vcount = 10'(vc);
        for (int x = 0; x <= 640; x++) begin
            tick();
            if (x > 0) got_line[x-1] = vcount[0] ? int'(color_code_o) : int'(color_code_e);
            if (x < 640) begin
                rd_x  = 10'(x);
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
        end
    endtask

    task automatic build_exp(input int t);
        int c;
        int code;
        for (int x = 0; x < 640; x++) exp_line[x] = 0;
        for (int i = 0; i < 32; i++) begin
            if (sh_n[i] != 0 && t >= sh_y[i] && (t - sh_y[i]) < 32) begin
                for (int k = 0; k < 32; k++) begin
                    c = (HF_EN && sh_hf[i] != 0) ? 31 - k : k;
                    code = int'(rom_code(sh_n[i], t - sh_y[i], c));
                    if (code != 0 && sh_x[i] + k < 640) exp_line[sh_x[i] + k] = code;
                end
            end
        end
    endtask

    task automatic compare_line(input string tag, input int t);
        int nerr;
        build_exp(t);
        nerr = 0;
        for (int x = 0; x < 640; x++) if (got_line[x] != exp_line[x]) nerr++;
        check_eq(tag, nerr, 0);
    endtask

    task automatic check_zero(input string tag, input int lo, input int hi);
        int nz;
        nz = 0;
        for (int x = lo; x <= hi; x++) if (got_line[x] != 0) nz++;
        check_eq(tag, nz, 0);
    endtask

    task automatic check_pix_seq(input string tag, input int hf);
        int errs;
        exp_q.delete();
        for (int k = 0; k < 32; k++) exp_q.push_back((HF_EN && hf != 0) ? 6'(31 - k) : 6'(k));
        errs = 0;
        if (pix_q.size() < 32) errs = 32;
        else for (int k = 0; k < 32; k++) if (pix_q[k] != exp_q[k]) errs++;
        check_eq(tag, errs, 0);
    endtask

    initial begin
        reset = 1'b1; attr_we = 1'b0; attr_addr = 5'd0; attr_data = 27'd0;
        line_start = 1'b0; vcount = 10'd0; rd_x = 10'd0; rd_en = 1'b0; overrun_clr = 1'b0;
        repeat (3) tick();

        // reset state
        check_eq("rst_n_sprite", n_sprite, 0);
        check_eq("rst_line", line, 0);
        check_eq("rst_pixel", pixel, 0);
        check_eq("rst_cc_e", color_code_e, 0);
        check_eq("rst_cc_o", color_code_o, 0);
        check_eq("rst_select", select, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_state", fsm_state, 0);
        reset = 1'b0;

        clear_attrs();
        read_line(0);
        read_line(1);

        // single sprite: n=1 x=100 y=50, rendered for line 50
        wr_attr(0, 0, 1, 50, 100);
        render(49);
        check_eq("single_busy", busy_cnt, 65);
        check_eq("single_span", span_cnt, 66);
        check_eq("single_row", line_max, 0);
        check_pix_seq("single_pix_seq", 0);
        read_line(50);
        check_eq("single_select", select, 0);
        check_eq("single_x100", got_line[100], 1);
        check_eq("single_x101", got_line[101], 2);
        check_eq("single_x103", got_line[103], 0);
        check_eq("single_x130", got_line[130], 15);
        check_eq("single_x131", got_line[131], 0);
        check_zero("single_left", 0, 99);
        check_zero("single_right", 132, 639);
        compare_line("single_line", 50);
        read_line(50);
        check_zero("single_cleared", 0, 639);

        // overlap: entry 5 over entry 3, row 3 of both, odd buffer
        wr_attr(0, 0, 0, 0, 0);
        wr_attr(3, 0, 18, 60, 200);
        wr_attr(5, 0, 19, 60, 210);
        render(62);
        check_eq("ovl_busy", busy_cnt, 32 + 66);
        check_eq("ovl_row", line_max, 3);
        read_line(63);
        check_eq("ovl_select", select, 1);
        check_eq("ovl_x210", got_line[210], 9);
        check_eq("ovl_x211", got_line[211], 10);
        check_eq("ovl_x213", got_line[213], 5);
        compare_line("ovl_line", 63);

        // clipping at the right edge, and y values that never hit on line 300
        wr_attr(3, 0, 0, 0, 0);
        wr_attr(5, 0, 0, 0, 0);
        wr_attr(7, 0, 2, 300, 620);
        wr_attr(9, 0, 4, 0, 400);
        wr_attr(10, 0, 5, 1000, 300);
        render(299);
        check_eq("clip_busy", busy_cnt, 65);
        read_line(300);
        check_eq("clip_x620", got_line[620], 2);
        check_eq("clip_x638", got_line[638], 4);
        check_eq("clip_x639", got_line[639], 0);
        check_zero("clip_nowrap", 0, 11);
        compare_line("clip_line", 300);

        // frame wrap: vcount 524 targets line 0 in the even buffer
        render(524);
        check_eq("wrap_busy", busy_cnt, 65);
        read_line(0);
        check_eq("wrap_x400", got_line[400], 4);
        check_eq("wrap_x401", got_line[401], 5);
        check_eq("wrap_x300", got_line[300], 0);
        compare_line("wrap_line", 0);
        read_line(1);
        check_zero("wrap_odd_blank", 0, 639);

        // overrun: all 32 entries hit, second line_start mid-render
        for (int i = 0; i < 32; i++) wr_attr(i, 0, i + 1, 100, i * 16);
        vcount = 10'd99;
        start_line();
        repeat (498) tick();
        check_eq("ovr_busy_before", busy, 1);
        start_line();
        check_eq("ovr_set", overrun, 1);
        check_eq("ovr_restart_state", fsm_state, 1);
        run_to_idle();
        check_eq("ovr_first_n", first_n, 1);
        check_eq("ovr_full_busy", busy_cnt, 1088);
        check_eq("ovr_sticky", overrun, 1);
        read_line(100);
        compare_line("ovr_line", 100);
        tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check_eq("ovr_clr", overrun, 0);

        // overrun and clear in the same cycle: overrun wins
        vcount = 10'd99;
        start_line();
        repeat (100) tick();
        line_start  = 1'b1;
        overrun_clr = 1'b1;
        tick();
        line_start  = 1'b0;
        overrun_clr = 1'b0;
        check_eq("ovr_prio", overrun, 1);
        run_to_idle();
        read_line(100);
        compare_line("ovr_prio_line", 100);

        // reset in the middle of a fetch (overrun still set, select = 1)
        clear_attrs();
        wr_attr(0, 0, 6, 20, 50);
        vcount = 10'd19;
        start_line();
        span_cnt = 0;
        while (!(fsm_state == 2'd2 && pixel == 6'd10) && span_cnt < 200) begin
            tick();
            span_cnt++;
        end
        check_eq("rstm_reached_k10", (span_cnt < 200), 1);
        check_eq("rstm_select_before", select, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("rstm_state", fsm_state, 0);
        check_eq("rstm_busy", busy, 0);
        check_eq("rstm_n_sprite", n_sprite, 0);
        check_eq("rstm_pixel", pixel, 0);
        check_eq("rstm_overrun", overrun, 0);
        check_eq("rstm_select", select, 0);
        tick();
        reset = 1'b0;
        render(19);
        check_eq("rstm_busy_after", busy_cnt, 65);
        check_pix_seq("rstm_pix_seq", 0);
        read_line(20);
        compare_line("rstm_line", 20);

        // horizontal flip bit set on entry 0
        wr_attr(0, 1, 9, 70, 300);
        render(69);
        check_pix_seq("hf_pix_seq", 1);
        read_line(70);
        check_eq("hf_x300", got_line[300], HF_EN ? 0 : 9);
        check_eq("hf_x301", got_line[301], HF_EN ? 7 : 10);
        compare_line("hf_line", 70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
